// File: rtl/sd_card_cmd_if.sv
// CMD-line bundle between the SD card PHY and its host-side driver/core.
// The PHY is the slave end; the bench or core is the master end.
interface sd_card_cmd_if;
  logic        cmd_pin_in;
  logic        cmd_pin_out;
  logic        cmd_oe;
  logic        cmd_strobe;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        frame_error;
  logic        resp_ready;
  logic        resp_valid;
  logic        resp_skip;
  logic [37:0] resp_content;
  logic        tx_done;

  modport master (
    output cmd_pin_in, resp_valid, resp_skip, resp_content,
    input  cmd_pin_out, cmd_oe, cmd_strobe, cmd_index, cmd_arg,
    input  frame_error, resp_ready, tx_done
  );

  modport slave (
    input  cmd_pin_in, resp_valid, resp_skip, resp_content,
    output cmd_pin_out, cmd_oe, cmd_strobe, cmd_index, cmd_arg,
    output frame_error, resp_ready, tx_done
  );
endinterface

// File: rtl/sd_card_cmd_phy.sv
// Card-side SD CMD line PHY: receives and CRC7-checks host commands,
// then serialises the core's 48-bit response after an N_CR high gap.
module sd_card_cmd_phy #(
  parameter int N_CR    = 2,
  parameter int FRAME_W = 48
) (
  input logic          sd_clock,
  input logic          reset,
  sd_card_cmd_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, RX, CHECK, WAIT_RESP, GAP, TX
  } state_t;

  state_t             state;
  logic [5:0]         cnt;
  logic [FRAME_W-1:0] rx_sr;
  logic [FRAME_W-1:0] tx_sr;
  logic [6:0]         crc;
  logic [FRAME_W-1:0] rx_next;
  logic               frame_ok;

  function automatic logic [6:0] crc7_step(
    input logic [6:0] c,
    input logic       b
  );
    logic fb;
    fb = b ^ c[6];
    return {c[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
  endfunction

  function automatic logic [6:0] crc7_word(input logic [39:0] d);
    logic [6:0] c;
    c = '0;
    for (int i = 39; i >= 0; i--) c = crc7_step(c, d[i]);
    return c;
  endfunction

  assign rx_next  = {rx_sr[FRAME_W-2:0], bus.cmd_pin_in};
  assign frame_ok = !rx_sr[47] && rx_sr[46] && rx_sr[0]
                    && (rx_sr[7:1] == crc);

  always_ff @(posedge sd_clock or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      cnt             <= '0;
      rx_sr           <= '0;
      tx_sr           <= '0;
      crc             <= '0;
      bus.cmd_pin_out <= 1'b1;
      bus.cmd_oe      <= 1'b0;
      bus.cmd_strobe  <= 1'b0;
      bus.cmd_index   <= '0;
      bus.cmd_arg     <= '0;
      bus.frame_error <= 1'b0;
      bus.resp_ready  <= 1'b0;
      bus.tx_done     <= 1'b0;
    end else begin
      bus.cmd_strobe  <= 1'b0;
      bus.frame_error <= 1'b0;
      bus.tx_done     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!bus.cmd_oe && !bus.cmd_pin_in) begin
            state <= RX;
            cnt   <= 6'd1;
            crc   <= '0;
            rx_sr <= '0;
          end
        end
        RX: begin
          rx_sr <= rx_next;
          // CRC covers start..argument only (bits 47..8)
          if (cnt < 6'd40) crc <= crc7_step(crc, bus.cmd_pin_in);
          if (cnt == 6'(FRAME_W - 1)) state <= CHECK;
          else cnt <= cnt + 6'd1;
        end
        CHECK: begin
          if (frame_ok) begin
            bus.cmd_strobe <= 1'b1;
            bus.cmd_index  <= rx_sr[45:40];
            bus.cmd_arg    <= rx_sr[39:8];
            bus.resp_ready <= 1'b1;
            state          <= WAIT_RESP;
          end else begin
            bus.frame_error <= 1'b1;
            state           <= IDLE;
          end
        end
        WAIT_RESP: begin
          if (bus.resp_valid) begin
            tx_sr <= {2'b00, bus.resp_content,
                      crc7_word({2'b00, bus.resp_content}), 1'b1};
            bus.resp_ready  <= 1'b0;
            bus.cmd_oe      <= 1'b1;
            bus.cmd_pin_out <= 1'b1;
            cnt             <= '0;
            state           <= GAP;
          end else if (bus.resp_skip) begin
            bus.resp_ready <= 1'b0;
            state          <= IDLE;
          end
        end
        GAP: begin
          if (cnt == 6'(N_CR - 1)) begin
            bus.cmd_pin_out <= tx_sr[FRAME_W-1];
            tx_sr           <= tx_sr << 1;
            cnt             <= 6'd1;
            state           <= TX;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        TX: begin
          if (cnt == 6'(FRAME_W)) begin
            bus.cmd_oe      <= 1'b0;
            bus.cmd_pin_out <= 1'b1;
            bus.tx_done     <= 1'b1;
            state           <= IDLE;
          end else begin
            bus.cmd_pin_out <= tx_sr[FRAME_W-1];
            tx_sr           <= tx_sr << 1;
            cnt             <= cnt + 6'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_card_cmd_phy.sv
// Bench for sd_card_cmd_phy: host driver plus card-core stub, with
// queue-based scoreboards for decoded commands and line responses.
module tb_sd_card_cmd_phy;

  localparam int NCR = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sd_card_cmd_if bus();

  sd_card_cmd_phy #(.N_CR(NCR)) dut (
    .sd_clock(clk),
    .reset   (rst),
    .bus     (bus.slave)
  );

  typedef struct {
    bit          good;
    logic [5:0]  idx;
    logic [31:0] arg;
    int          end_cyc;
  } exp_cmd_t;

  int          checks = 0;
  int          fails  = 0;
  int          cyc    = 0;
  exp_cmd_t    cmd_q[$];
  logic [47:0] resp_q[$];
  logic [5:0]  m_idx = '0;
  logic [31:0] m_arg = '0;

  exp_cmd_t    mon_e;
  bit          cap[$];
  bit          prev_oe = 1'b0;
  logic [47:0] mon_exp;
  logic [47:0] mon_got;
  bit          gap_ok;

  always @(posedge clk) cyc++;

  function automatic void check(string name, logic [63:0] act,
                                logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               name, act, exp, cyc);
    end
  endfunction

  // Polynomial long division of data*x^7 by x^7+x^3+1
  function automatic logic [6:0] crc_model(input logic [39:0] d);
    logic [46:0] r;
    r = {d, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r = r ^ (47'h89 << (i - 7));
    return r[6:0];
  endfunction

  function automatic logic [47:0] mk_frame(input bit tbit,
      input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] h;
    h = {1'b0, tbit, idx, arg};
    return {h, crc_model(h), 1'b1};
  endfunction

  // Command scoreboard and response line monitor
  always @(negedge clk) begin
    if (rst) begin
      cap.delete();
      prev_oe = 1'b0;
    end else begin
      if (bus.cmd_strobe || bus.frame_error) begin
        if (cmd_q.size() == 0) begin
          check("unexpected_cmd_event", 1, 0);
        end else begin
          mon_e = cmd_q.pop_front();
          check("cmd_strobe", bus.cmd_strobe, mon_e.good);
          check("frame_error", bus.frame_error, !mon_e.good);
          check("cmd_index", bus.cmd_index, mon_e.idx);
          check("cmd_arg", bus.cmd_arg, mon_e.arg);
          check("event_latency", cyc, mon_e.end_cyc + 1);
        end
      end else if (cmd_q.size() != 0 && cyc > cmd_q[0].end_cyc + 1) begin
        check("cmd_event_missing", 0, 1);
        void'(cmd_q.pop_front());
      end
      if (bus.cmd_oe) begin
        if (!prev_oe) check("oe_rise_expected", resp_q.size() != 0, 1);
        cap.push_back(bus.cmd_pin_out);
      end
      if (prev_oe && !bus.cmd_oe) begin
        check("tx_done_with_release", bus.tx_done, 1);
        check("resp_len", cap.size(), NCR + 48);
        if (resp_q.size() != 0 && cap.size() == NCR + 48) begin
          mon_exp = resp_q.pop_front();
          gap_ok = 1'b1;
          for (int i = 0; i < NCR; i++) gap_ok = gap_ok & cap[i];
          for (int i = 0; i < 48; i++) mon_got[47-i] = cap[NCR+i];
          check("resp_gap_high", gap_ok, 1);
          check("resp_frame", mon_got, mon_exp);
        end else if (resp_q.size() != 0) begin
          void'(resp_q.pop_front());
        end
        cap.delete();
      end else if (bus.tx_done) begin
        check("tx_done_spurious", 1, 0);
      end
      prev_oe = bus.cmd_oe;
    end
  end

  task automatic drive_frame(input logic [47:0] f, input int nbits);
    exp_cmd_t e;
    bit good;
    for (int i = 47; i > 47 - nbits; i--) begin
      @(negedge clk);
      bus.cmd_pin_in = f[i];
    end
    if (nbits == 48) begin
      good = !f[47] && f[46] && f[0] && (f[7:1] == crc_model(f[47:8]));
      if (good) begin
        m_idx = f[45:40];
        m_arg = f[39:8];
      end
      e.good    = good;
      e.idx     = m_idx;
      e.arg     = m_arg;
      e.end_cyc = cyc + 1;
      cmd_q.push_back(e);
      @(negedge clk);
      bus.cmd_pin_in = 1'b1;
    end
  endtask

  // mode 0: skip, 1: valid, 2: valid and skip together
  task automatic respond(input int mode, input logic [37:0] c,
                         input bit wait_done);
    int n;
    n = 0;
    while (!bus.resp_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("resp_ready_seen", bus.resp_ready, 1);
    if (bus.resp_ready) begin
      bus.resp_content = c;
      bus.resp_valid   = (mode != 0);
      bus.resp_skip    = (mode != 1);
      if (mode != 0)
        resp_q.push_back({2'b00, c, crc_model({2'b00, c}), 1'b1});
      @(negedge clk);
      bus.resp_valid = 1'b0;
      bus.resp_skip  = 1'b0;
      if (mode != 0 && wait_done) begin
        n = 0;
        while (!bus.tx_done && n < 200) begin
          @(negedge clk);
          n++;
        end
        check("tx_done_seen", bus.tx_done, 1);
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_pin_out"}, bus.cmd_pin_out, 1);
    check({tag, "_oe"}, bus.cmd_oe, 0);
    check({tag, "_strobe"}, bus.cmd_strobe, 0);
    check({tag, "_ferr"}, bus.frame_error, 0);
    check({tag, "_ready"}, bus.resp_ready, 0);
    check({tag, "_tx_done"}, bus.tx_done, 0);
    check({tag, "_index"}, bus.cmd_index, 0);
    check({tag, "_arg"}, bus.cmd_arg, 0);
  endtask

  task automatic async_reset(input string tag);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 check_reset_vals(tag);
    resp_q.delete();
    m_idx = '0;
    m_arg = '0;
    bus.cmd_pin_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [47:0] f;
    int          kind;
    bus.cmd_pin_in   = 1'b1;
    bus.resp_valid   = 1'b0;
    bus.resp_skip    = 1'b0;
    bus.resp_content = '0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);

    drive_frame(48'h40_0000_0000_95, 48);
    respond(0, '0, 1'b0);
    drive_frame(48'h48_0000_01AA_87, 48);
    respond(1, {6'd8, 32'h0000_01AA}, 1'b1);

    drive_frame(48'h40_0000_0000_97, 48);
    repeat (3) @(negedge clk);
    check("bad_crc_oe_low", bus.cmd_oe, 0);

    drive_frame(48'h48_0000_01AA_86, 48);
    drive_frame(48'h48_0000_01AA_87, 48);
    respond(2, {6'd8, 32'h0000_01AA}, 1'b1);

    drive_frame(mk_frame(1'b0, 6'd17, 32'h0000_1234), 48);
    drive_frame(mk_frame(1'b1, 6'd55, 32'hDEAD_BEEF), 48);
    respond(1, {6'd55, 32'h0BAD_F00D}, 1'b1);

    drive_frame(mk_frame(1'b1, 6'd9, 32'hCAFE_0001), 20);
    async_reset("rst_mid_rx");
    drive_frame(48'h40_0000_0000_95, 48);
    respond(0, '0, 1'b0);

    drive_frame(mk_frame(1'b1, 6'd41, 32'h1357_9BDF), 48);
    respond(1, {6'd41, 32'h2468_ACE0}, 1'b0);
    repeat (15) @(negedge clk);
    check("mid_tx_oe_high", bus.cmd_oe, 1);
    async_reset("rst_mid_tx");
    drive_frame(48'h48_0000_01AA_87, 48);
    respond(1, {6'd8, 32'h0000_01AA}, 1'b1);

    for (int it = 0; it < 30; it++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      kind = $urandom_range(0, 5);
      f = mk_frame(kind != 2, 6'($urandom), $urandom);
      if (kind == 0) f[$urandom_range(1, 7)] ^= 1'b1;
      if (kind == 1) f[0] = 1'b0;
      drive_frame(f, 48);
      if (kind >= 3)
        respond($urandom_range(0, 2), {6'($urandom), 32'($urandom)}, 1'b1);
      else
        repeat (3) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    check("cmd_q_drained", cmd_q.size(), 0);
    check("resp_q_drained", resp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
